// File: rtl/rv32i_dmem.sv
// RV32I data memory: byte-enabled word array behind a 1-entry posted write buffer,
// with buffered bytes merged into the combinational read. Optional MMIO via DMEM_MMIO_EN.
module rv32i_dmem #(
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [1:0]  MemWriteM,
  output logic [31:0] ReadDataMTick,
  output logic        MisalignedM,
  output logic [15:0] StoreCountM
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] gpio_out
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic          r_buf_valid;
  logic [AW-1:0] r_buf_idx;
  logic [3:0]    r_buf_be;
  logic [31:0]   r_buf_data;
  logic          r_mis;
  logic [15:0]   r_cnt;

  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_misaligned;
  logic          w_store;
  logic          w_ram_store;
  logic          w_is_gpio;
  logic          w_is_timer;
  logic [31:0]   w_raw;
  logic [31:0]   w_rdata;

  assign w_idx = ALUResultM[AW+1:2];

  always_comb begin
    w_be         = 4'b0000;
    w_wdata      = WriteDataM;
    w_misaligned = 1'b0;
    case (MemWriteM)
      2'b01: begin
        w_be    = 4'b0001 << ALUResultM[1:0];
        w_wdata = {4{WriteDataM[7:0]}};
      end
      2'b10: begin
        w_be         = ALUResultM[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{WriteDataM[15:0]}};
        w_misaligned = ALUResultM[0];
      end
      2'b11: begin
        w_be         = 4'b1111;
        w_misaligned = |ALUResultM[1:0];
      end
      default: ;
    endcase
  end

  assign w_store = (MemWriteM != 2'b00) && !w_misaligned;

`ifdef DMEM_MMIO_EN
  logic [31:0] r_gpio;
  logic [31:0] r_cycle;

  assign w_is_gpio  = (ALUResultM[31:2] == 30'h3FFF_FFFC);
  assign w_is_timer = (ALUResultM[31:2] == 30'h3FFF_FFFD);
  assign gpio_out   = r_gpio;

  // GPIO stores bypass the buffer and land at the edge they are presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio  <= 32'h0;
      r_cycle <= 32'h0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_store && w_is_gpio) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i]) r_gpio[i*8 +: 8] <= w_wdata[i*8 +: 8];
        end
      end
    end
  end
`else
  assign w_is_gpio  = 1'b0;
  assign w_is_timer = 1'b0;
`endif

  assign w_ram_store = w_store && !w_is_gpio && !w_is_timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_mis       <= 1'b0;
      r_cnt       <= 16'h0;
    end else begin
      r_buf_valid <= w_ram_store;
      if (w_ram_store) begin
        r_buf_idx  <= w_idx;
        r_buf_be   <= w_be;
        r_buf_data <= w_wdata;
      end
      if ((MemWriteM != 2'b00) && w_misaligned) r_mis <= 1'b1;
      if (w_store && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
    end
  end

  // Any valid entry drains at every edge; a new store simply refills the buffer behind it.
  always_ff @(posedge clk) begin
    if (!rst && r_buf_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (r_buf_be[i]) r_mem[r_buf_idx][i*8 +: 8] <= r_buf_data[i*8 +: 8];
      end
    end
  end

  assign w_raw = r_mem[w_idx];

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign w_rdata[gi*8 +: 8] = (r_buf_valid && (r_buf_idx == w_idx) && r_buf_be[gi])
                                ? r_buf_data[gi*8 +: 8] : w_raw[gi*8 +: 8];
  end

`ifdef DMEM_MMIO_EN
  assign ReadDataMTick = w_is_gpio ? r_gpio : (w_is_timer ? r_cycle : w_rdata);
`else
  assign ReadDataMTick = w_rdata;
`endif

  assign MisalignedM = r_mis;
  assign StoreCountM = r_cnt;

endmodule

// File: tb/tb_rv32i_dmem.sv
// Randomized scoreboard bench for rv32i_dmem (default build) against a plain word-array model.
module tb_rv32i_dmem;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [1:0]  MemWriteM;
  logic [31:0] ReadDataMTick;
  logic        MisalignedM;
  logic [15:0] StoreCountM;

  always #5 clk = ~clk;

  rv32i_dmem #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .MemWriteM(MemWriteM),
    .ReadDataMTick(ReadDataMTick),
    .MisalignedM(MisalignedM),
    .StoreCountM(StoreCountM)
  );

  typedef struct {
    logic [31:0] data;
    bit          has_data;
    logic        mis;
    logic [15:0] cnt;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[$];
  string       name_q[$];
  bit          chk_en = 1'b0;

  logic [31:0] m_mem [DEPTH];
  logic        m_mis;
  logic [15:0] m_cnt;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % DEPTH);
  endfunction

  // Architectural view: an accepted store takes effect immediately.
  function automatic void model_store(input logic [1:0] mw, input logic [31:0] a,
                                      input logic [31:0] wd);
    logic [31:0] w;
    int lane;
    w    = m_mem[widx(a)];
    lane = int'(a % 32'd4);
    if (mw == 2'd1) begin
      w[lane*8 +: 8] = wd[7:0];
    end else if (mw == 2'd2) begin
      if (lane % 2 != 0) begin
        m_mis = 1'b1;
        return;
      end
      w[lane*8 +: 16] = wd[15:0];
    end else begin
      if (lane != 0) begin
        m_mis = 1'b1;
        return;
      end
      w = wd;
    end
    m_mem[widx(a)] = w;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endfunction

  // chk: 0 none, 1 data+status, 2 status only
  task automatic op(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] wd,
                    input int chk, input string nm, input bit upd);
    exp_t e;
    MemWriteM  = mw;
    ALUResultM = a;
    WriteDataM = wd;
    chk_en     = (chk != 0);
    if (chk != 0) begin
      e.data     = m_mem[widx(a)];
      e.has_data = (chk == 1);
      e.mis      = m_mis;
      e.cnt      = m_cnt;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    if (mw != 2'd0 && upd) model_store(mw, a, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op(2'd0, 32'h0, 32'h0, 0, "", 1'b0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    MemWriteM = 2'd0;
    chk_en    = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_mis = 1'b0;
    m_cnt = 16'h0;
  endtask

  // Monitor: pops one expectation per presented check cycle.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got check request, want queued expectation");
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (e.has_data) begin
            checks++;
            if (ReadDataMTick !== e.data) begin
              errors++;
              $display("FAIL %s data: got %08h want %08h addr %08h", n, ReadDataMTick, e.data, ALUResultM);
            end
          end
          checks++;
          if (MisalignedM !== e.mis) begin
            errors++;
            $display("FAIL %s misaligned: got %0b want %0b", n, MisalignedM, e.mis);
          end
          checks++;
          if (StoreCountM !== e.cnt) begin
            errors++;
            $display("FAIL %s count: got %04h want %04h", n, StoreCountM, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int r;
    rst        = 1'b1;
    MemWriteM  = 2'd0;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    m_mis      = 1'b0;
    m_cnt      = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    op(2'd0, 32'h0, 32'h0, 2, "reset_state", 1'b0);

    for (int i = 0; i < DEPTH; i++) op(2'd3, 32'(i * 4), $urandom, 0, "", 1'b1);
    idle();
    op(2'd0, 32'h0, 32'h0, 1, "init_count", 1'b0);

    op(2'd3, 32'h10, 32'hDEADBEEF, 0, "", 1'b1);
    op(2'd0, 32'h10, 32'h0, 1, "raw_from_buffer", 1'b0);
    idle();
    op(2'd0, 32'h10, 32'h0, 1, "raw_after_commit", 1'b0);

    op(2'd3, 32'h20, 32'h11223344, 0, "", 1'b1);
    op(2'd1, 32'h21, 32'h000000AA, 0, "", 1'b1);
    op(2'd2, 32'h22, 32'h00005566, 0, "", 1'b1);
    op(2'd0, 32'h20, 32'h0, 1, "byte_merge", 1'b0);

    // Store buffered when rst arrives, plus a store presented during rst: both lost.
    idle();
    op(2'd3, 32'h40, 32'hCAFEF00D, 0, "", 1'b0);
    rst        = 1'b1;
    MemWriteM  = 2'd3;
    ALUResultM = 32'h44;
    WriteDataM = 32'h12345678;
    chk_en     = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_mis = 1'b0;
    m_cnt = 16'h0;
    op(2'd0, 32'h40, 32'h0, 1, "rst_drops_buffer", 1'b0);
    op(2'd0, 32'h44, 32'h0, 1, "rst_drops_store", 1'b0);

    op(2'd3, 32'h30, 32'h0BADF00D, 0, "", 1'b1);
    op(2'd2, 32'h31, 32'h0000FFFF, 0, "", 1'b1);
    op(2'd0, 32'h30, 32'h0, 1, "misaligned_sh", 1'b0);
    op(2'd3, 32'h32, 32'hFFFFFFFF, 0, "", 1'b1);
    repeat (4) idle();
    op(2'd0, 32'h30, 32'h0, 1, "misaligned_sticky", 1'b0);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 3));
      a = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 511);
      if (r == 0) op(2'd0, a, $urandom, 1, "random_load", 1'b0);
      else        op(2'(r), a, $urandom, 0, "", 1'b1);
    end

    idle();
    do_reset();
    op(2'd0, 32'h10, 32'h0, 1, "after_reset", 1'b0);
    for (int i = 0; i < 65537; i++) op(2'd3, $urandom & 32'hFFFF_FFFC, $urandom, 0, "", 1'b1);
    op(2'd0, $urandom, 32'h0, 1, "count_saturated", 1'b0);
    op(2'd3, 32'h8, 32'h01020304, 0, "", 1'b1);
    op(2'd0, 32'h8, 32'h0, 1, "count_stays_saturated", 1'b0);
    repeat (3) idle();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
